lap_controller: RTL and testbench

- Control sequencer for the stopwatch counter datapath (minutes/seconds/10 ms counter).
- Turns three button levels into counter enable and clear, captures lap times into a small buffer, and lets the user review stored laps on the display.
- Sits between the debounced button inputs and the counter core. Drives the counter's enable and clear, and muxes live or stored time onto the display outputs.

---
 rtl/lap_controller.sv | 161 ++++++++++++++++
 tb/tb_lap_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_controller.sv
// ============================================================================
// lap_controller
// Stopwatch control sequencer: button edges -> counter enable/clear, lap
// capture into a small buffer, and live/stored time display mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lap_controller #(
   parameter  int DEPTH = 4,
   localparam int IW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pause_btn,
   input  logic          record_btn,
   input  logic          view_btn,
   input  logic [5:0]    min_i,
   input  logic [5:0]    sec_i,
   input  logic [6:0]    ms_10_i,
   output logic          cnt_en,
   output logic          cnt_clr,
   output logic [5:0]    min_o,
   output logic [5:0]    sec_o,
   output logic [6:0]    ms_10_o,
   output logic          review,
   output logic [IW-1:0] lap_idx,
   output logic [CW-1:0] lap_count,
   output logic          full
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      REVIEW = 2'd3
   } state_t;

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   state_t        state;
   state_t        ret_state;
   logic          pause_prev;
   logic          record_prev;
   logic          view_prev;
   logic [18:0]   lap_mem [DEPTH];

   state_t        state_nxt;
   state_t        ret_nxt;
   logic [IW-1:0] idx_nxt;
   logic [CW-1:0] count_nxt;
   logic          clr_nxt;
   logic          lap_wr;
   logic          act_pause;
   logic          act_record;
   logic          act_view;
   logic          have_laps;
   logic [18:0]   disp_nxt;
   logic [18:0]   live_time;

   // Only the highest-priority edge in a cycle is acted on; the rest are lost.
   assign act_pause  = pause_btn & ~pause_prev;
   assign act_record = record_btn & ~record_prev & ~act_pause;
   assign act_view   = view_btn & ~view_prev & ~act_pause & ~(record_btn & ~record_prev);
   assign have_laps  = (lap_count != '0);
   assign live_time  = {min_i, sec_i, ms_10_i};

   always_comb begin
      state_nxt = state;
      ret_nxt   = ret_state;
      idx_nxt   = lap_idx;
      count_nxt = lap_count;
      clr_nxt   = 1'b0;
      lap_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (act_pause) begin
               state_nxt = RUN;
            end else if (act_view && have_laps) begin
               state_nxt = REVIEW;
               ret_nxt   = IDLE;
               idx_nxt   = '0;
            end
         end
         RUN: begin
            if (act_pause) begin
               state_nxt = PAUSED;
            end else if (act_record && (lap_count != FULL_COUNT)) begin
               lap_wr    = 1'b1;
               count_nxt = lap_count + 1'b1;
            end
         end
         PAUSED: begin
            if (act_pause) begin
               state_nxt = RUN;
            end else if (act_record) begin
               clr_nxt   = 1'b1;
               count_nxt = '0;
               state_nxt = IDLE;
            end else if (act_view && have_laps) begin
               state_nxt = REVIEW;
               ret_nxt   = PAUSED;
               idx_nxt   = '0;
            end
         end
         REVIEW: begin
            if (act_pause || act_view) begin
               state_nxt = ret_state;
            end else if (act_record) begin
               idx_nxt = ({1'b0, lap_idx} == (lap_count - 1'b1)) ? '0 : lap_idx + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The display follows the next state so review entry shows lap 0 immediately.
   assign disp_nxt = (state_nxt == REVIEW) ? lap_mem[idx_nxt] : live_time;

   always_ff @(posedge clk) begin
      if (lap_wr) begin
         lap_mem[lap_count[IW-1:0]] <= live_time;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ret_state   <= IDLE;
         pause_prev  <= 1'b1;
         record_prev <= 1'b1;
         view_prev   <= 1'b1;
         cnt_en      <= 1'b0;
         cnt_clr     <= 1'b1;
         min_o       <= '0;
         sec_o       <= '0;
         ms_10_o     <= '0;
         review      <= 1'b0;
         lap_idx     <= '0;
         lap_count   <= '0;
         full        <= 1'b0;
      end else begin
         state       <= state_nxt;
         ret_state   <= ret_nxt;
         pause_prev  <= pause_btn;
         record_prev <= record_btn;
         view_prev   <= view_btn;
         cnt_en      <= (state_nxt == RUN);
         cnt_clr     <= clr_nxt;
         {min_o, sec_o, ms_10_o} <= disp_nxt;
         review      <= (state_nxt == REVIEW);
         lap_idx     <= idx_nxt;
         lap_count   <= count_nxt;
         full        <= (count_nxt == FULL_COUNT);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lap_controller.sv
// ============================================================================
// tb_lap_controller
// Directed stimulus with a queue-based behavioural model checked every cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lap_controller;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pause_btn = 1'b0;
   logic       record_btn = 1'b0;
   logic       view_btn = 1'b0;
   logic [5:0] min_i = '0;
   logic [5:0] sec_i = '0;
   logic [6:0] ms_10_i = '0;
   logic       cnt_en;
   logic       cnt_clr;
   logic [5:0] min_o;
   logic [5:0] sec_o;
   logic [6:0] ms_10_o;
   logic       review;
   logic [1:0] lap_idx;
   logic [2:0] lap_count;
   logic       full;

   int tests = 0;
   int fails = 0;

   lap_controller #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pause_btn  (pause_btn),
      .record_btn (record_btn),
      .view_btn   (view_btn),
      .min_i      (min_i),
      .sec_i      (sec_i),
      .ms_10_i    (ms_10_i),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .min_o      (min_o),
      .sec_o      (sec_o),
      .ms_10_o    (ms_10_o),
      .review     (review),
      .lap_idx    (lap_idx),
      .lap_count  (lap_count),
      .full       (full)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode 0 idle, 1 running, 2 paused, 3 reviewing.
   int          m_mode = 0;
   int          m_ret = 0;
   int          m_idx = 0;
   logic [18:0] laps[$];
   bit          pp, rp, vp;
   bit          started = 0;
   logic        e_en, e_clr, e_review, e_full;
   logic [18:0] e_disp;
   int          e_count;

   always @(posedge clk) begin
      bit ep, er, ev;
      started = 1;
      if (rst) begin
         pp = 1; rp = 1; vp = 1;
         m_mode = 0; m_ret = 0; m_idx = 0;
         laps.delete();
         e_en = 0; e_clr = 1; e_review = 0; e_full = 0; e_disp = '0; e_count = 0;
      end else begin
         ep = pause_btn && !pp;
         er = record_btn && !rp && !ep;
         ev = view_btn && !vp && !ep && !(record_btn && !rp);
         pp = pause_btn; rp = record_btn; vp = view_btn;
         e_clr = 0;
         if (ep) begin
            if (m_mode == 0 || m_mode == 2) m_mode = 1;
            else if (m_mode == 1) m_mode = 2;
            else m_mode = m_ret;
         end else if (er) begin
            if (m_mode == 1 && laps.size() < DEPTH) laps.push_back({min_i, sec_i, ms_10_i});
            else if (m_mode == 2) begin
               laps.delete(); e_clr = 1; m_mode = 0;
            end else if (m_mode == 3) m_idx = (m_idx + 1) % laps.size();
         end else if (ev) begin
            if ((m_mode == 0 || m_mode == 2) && laps.size() > 0) begin
               m_ret = m_mode; m_mode = 3; m_idx = 0;
            end else if (m_mode == 3) m_mode = m_ret;
         end
         e_en = (m_mode == 1);
         e_review = (m_mode == 3);
         e_count = laps.size();
         e_full = (laps.size() == DEPTH);
         e_disp = (m_mode == 3) ? laps[m_idx] : {min_i, sec_i, ms_10_i};
      end
   end

   always @(negedge clk) begin
      if (started) begin
         tests = tests + 1;
         if (cnt_en !== e_en || cnt_clr !== e_clr || review !== e_review || full !== e_full ||
             {min_o, sec_o, ms_10_o} !== e_disp || int'(lap_count) != e_count ||
             int'(lap_idx) != m_idx) begin
            fails = fails + 1;
            $display("FAIL cycle_model t=%0t got en=%b clr=%b rev=%b full=%b disp=%h cnt=%0d idx=%0d exp en=%b clr=%b rev=%b full=%b disp=%h cnt=%0d idx=%0d",
                     $time, cnt_en, cnt_clr, review, full, {min_o, sec_o, ms_10_o}, lap_count, lap_idx,
                     e_en, e_clr, e_review, e_full, e_disp, e_count, m_idx);
         end
      end
   end

   task automatic check_lit(input string name, input int actual, input int expected);
      tests = tests + 1;
      if (actual != expected) begin
         fails = fails + 1;
         $display("FAIL %s got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic set_time(input int m, input int s, input int c);
      min_i = 6'(m); sec_i = 6'(s); ms_10_i = 7'(c);
   endtask

   // which: 0 pause, 1 record, 2 view
   task automatic press(input int which);
      @(negedge clk);
      if (which == 0) pause_btn = 1;
      else if (which == 1) record_btn = 1;
      else view_btn = 1;
      @(negedge clk);
      pause_btn = 0; record_btn = 0; view_btn = 0;
      @(negedge clk);
   endtask

   function automatic int disp_val();
      return int'({min_o, sec_o, ms_10_o});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: button held through reset fires nothing
      pause_btn = 1;
      rst = 1;
      repeat (3) @(negedge clk);
      check_lit("reset_clr", int'(cnt_clr), 1);
      check_lit("reset_count", int'(lap_count), 0);
      rst = 0;
      @(negedge clk);
      check_lit("post_reset_clr", int'(cnt_clr), 0);
      repeat (2) @(negedge clk);
      check_lit("held_pause_no_run", int'(cnt_en), 0);
      check_lit("held_disp_zero", disp_val(), 0);
      pause_btn = 0;
      @(negedge clk);

      // 2: run / pause / run
      press(0);
      check_lit("run1_en", int'(cnt_en), 1);
      press(0);
      check_lit("paused_en", int'(cnt_en), 0);
      press(0);
      check_lit("run2_en", int'(cnt_en), 1);

      // 3: two laps then review with wrap
      set_time(1, 2, 3);
      press(1);
      set_time(1, 5, 50);
      press(1);
      check_lit("two_laps", int'(lap_count), 2);
      set_time(2, 0, 0);
      press(0);
      press(2);
      check_lit("review_on", int'(review), 1);
      check_lit("review_lap0", disp_val(), 8451);
      press(1);
      check_lit("review_lap1", disp_val(), 8882);
      press(1);
      check_lit("review_wrap", disp_val(), 8451);
      press(2);
      check_lit("review_off", int'(review), 0);
      check_lit("back_paused_en", int'(cnt_en), 0);

      // 5: clear from paused, then view ignored
      @(negedge clk);
      record_btn = 1;
      @(negedge clk);
      record_btn = 0;
      check_lit("clr_pulse_hi", int'(cnt_clr), 1);
      check_lit("clr_count", int'(lap_count), 0);
      @(negedge clk);
      check_lit("clr_pulse_lo", int'(cnt_clr), 0);
      press(2);
      check_lit("view_ignored_empty", int'(review), 0);

      // 4: overfill the buffer
      press(0);
      for (int i = 0; i < 5; i++) begin
         set_time(3, 10 + i, 20 + i);
         press(1);
      end
      check_lit("full_count", int'(lap_count), 4);
      check_lit("full_flag", int'(full), 1);
      press(0);
      press(2);
      repeat (3) press(1);
      check_lit("lap3_idx", int'(lap_idx), 3);
      check_lit("lap3_kept", disp_val(), (3 << 13) | (13 << 7) | 23);
      press(2);

      // 6: simultaneous pause + record, then reset mid-review
      press(1);
      press(0);
      set_time(4, 4, 4);
      press(1);
      check_lit("one_lap", int'(lap_count), 1);
      @(negedge clk);
      pause_btn = 1; record_btn = 1;
      @(negedge clk);
      pause_btn = 0; record_btn = 0;
      check_lit("simul_paused", int'(cnt_en), 0);
      check_lit("simul_count", int'(lap_count), 1);
      press(2);
      check_lit("review_before_rst", int'(review), 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check_lit("rst_review_off", int'(review), 0);
      check_lit("rst_count", int'(lap_count), 0);
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
